// File: rtl/ita_package.sv
// Shared ITA constants and types used by the GELU requantization stage.
package ita_package;

    localparam int unsigned WI              = 8;
    localparam int unsigned GELU_OUT_WIDTH  = 26;

    localparam int unsigned REQ_N           = 16;
    localparam int unsigned REQ_EPS_WIDTH   = 8;
    localparam int unsigned REQ_SHIFT_WIDTH = 5;

    // One requantized output beat, lane 0 in the LSBs.
    typedef logic [REQ_N-1:0][WI-1:0] requant_oup_t;

endpackage

// File: rtl/ita_requant_lane.sv
// Combinational per-lane requant arithmetic: multiply, shift/round, bias add and clip.
// The three pieces are separated by pipeline registers held in the parent.
// Optional feature macro: ITA_REQUANT_ROUND_EN (round-half-up before the shift).
module ita_requant_lane
    import ita_package::*;
#(
    parameter  int unsigned EPS_WIDTH   = REQ_EPS_WIDTH,
    parameter  int unsigned SHIFT_WIDTH = REQ_SHIFT_WIDTH,
    localparam int unsigned PW          = GELU_OUT_WIDTH + EPS_WIDTH + 1
) (
    input  logic signed [GELU_OUT_WIDTH-1:0] data,
    input  logic        [EPS_WIDTH-1:0]      eps,
    output logic signed [PW-1:0]             prod_c,
    input  logic signed [PW-1:0]             prod,
    input  logic        [SHIFT_WIDTH-1:0]    shift,
    output logic signed [PW:0]               shifted_c,
    input  logic signed [PW:0]               shifted,
    input  logic signed [WI-1:0]             add,
    output logic signed [WI-1:0]             result_c
);

    logic signed [PW:0]        sum;
    logic signed [PW+1:0]      total;
    logic        [PW+2-WI:0]   hi;
`ifdef ITA_REQUANT_ROUND_EN
    logic signed [PW:0]        rnd;
`endif

    // Signed data times zero-extended multiplier; the product always fits in PW bits.
    always_comb begin
        prod_c = PW'(data) * $signed(PW'(eps));
    end

    // Optional half-LSB rounding term, then arithmetic right shift at PW+1 bits.
    always_comb begin
`ifdef ITA_REQUANT_ROUND_EN
        rnd = '0;
        if (shift != '0) begin
            rnd = (PW+1)'(1) << (shift - SHIFT_WIDTH'(1));
        end
        sum = (PW+1)'(prod) + rnd;
`else
        sum = (PW+1)'(prod);
`endif
        shifted_c = sum >>> shift;
    end

    // Bias add at PW+2 bits, then clip to the WI-bit signed range.
    always_comb begin
        total    = (PW+2)'(shifted) + (PW+2)'(add);
        hi       = total[PW+1:WI-1];
        result_c = total[WI-1:0];
        if (!((&hi) || !(|hi))) begin
            result_c = total[PW+1] ? {1'b1, {(WI-1){1'b0}}} : {1'b0, {(WI-1){1'b1}}};
        end
    end

endmodule

// File: rtl/ita_gelu_requant.sv
// Three-stage N-lane requantization of GELU results with valid/ready on both sides.
// Optional feature macro: ITA_REQUANT_ROUND_EN (round-half-up; floor truncation otherwise).
module ita_gelu_requant
    import ita_package::*;
#(
    parameter int unsigned N           = REQ_N,
    parameter int unsigned EPS_WIDTH   = REQ_EPS_WIDTH,
    parameter int unsigned SHIFT_WIDTH = REQ_SHIFT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [N*GELU_OUT_WIDTH-1:0]   data_i,
    input  logic [EPS_WIDTH-1:0]          eps_mult_i,
    input  logic [SHIFT_WIDTH-1:0]        right_shift_i,
    input  logic signed [WI-1:0]          add_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [N*WI-1:0]               data_o
);

    localparam int unsigned PW = GELU_OUT_WIDTH + EPS_WIDTH + 1;

    logic                    v1, v2;
    logic                    ld1, ld2, ld3;

    logic [N-1:0][PW-1:0]    prod_c;
    logic [N-1:0][PW-1:0]    prod_q;
    logic [SHIFT_WIDTH-1:0]  shift_q;
    logic [WI-1:0]           add_q1;

    logic [N-1:0][PW:0]      shifted_c;
    logic [N-1:0][PW:0]      shifted_q;
    logic [WI-1:0]           add_q2;

    logic [N-1:0][WI-1:0]    result_c;

    // Stage load enables; a stage loads when empty or when its successor loads.
    always_comb begin
        ld3     = !valid_o || ready_i;
        ld2     = !v2 || ld3;
        ld1     = !v1 || ld2;
        ready_o = ld1;
    end

    // Per-lane arithmetic between pipeline registers.
    for (genvar i = 0; i < N; i++) begin : g_lane
        ita_requant_lane #(
            .EPS_WIDTH   (EPS_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH)
        ) u_lane (
            .data      (data_i[i*GELU_OUT_WIDTH +: GELU_OUT_WIDTH]),
            .eps       (eps_mult_i),
            .prod_c    (prod_c[i]),
            .prod      (prod_q[i]),
            .shift     (shift_q),
            .shifted_c (shifted_c[i]),
            .shifted   (shifted_q[i]),
            .add       (add_q2),
            .result_c  (result_c[i])
        );
    end

    // Stage 1: capture products together with the beat's shift and bias.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1      <= 1'b0;
            prod_q  <= '0;
            shift_q <= '0;
            add_q1  <= '0;
        end else if (ld1) begin
            v1      <= valid_i;
            prod_q  <= prod_c;
            shift_q <= right_shift_i;
            add_q1  <= add_i;
        end
    end

    // Stage 2: capture shifted values and forward the bias.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2        <= 1'b0;
            shifted_q <= '0;
            add_q2    <= '0;
        end else if (ld2) begin
            v2        <= v1;
            shifted_q <= shifted_c;
            add_q2    <= add_q1;
        end
    end

    // Stage 3: saturated output beat, held while downstream stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (ld3) begin
            valid_o <= v2;
            data_o  <= result_c;
        end
    end

endmodule

// File: doc/ita_gelu_requant.md
# ita_gelu_requant

Pipelined, N-lane requantization stage that sits directly downstream of the GELU datapath. It consumes wide signed GELU results (GELU_OUT_WIDTH per lane) and converts them to WI-bit activations using multiply, arithmetic right shift, optional rounding, bias add and saturation. The result feeds the output FIFO toward the next layer. A valid/ready stream handshake on both sides gives full-throughput operation with backpressure.

## Interface
- N, 16: lanes processed per beat.
- EPS_WIDTH, 8: width of the unsigned requant multiplier.
- SHIFT_WIDTH, 5: width of the right-shift amount.
- clk_i  in  1  clock, all logic on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  stage can accept a beat.
- data_i  in  N×GELU_OUT_WIDTH  signed GELU results, lane 0 in the LSBs.
- eps_mult_i  in  EPS_WIDTH  unsigned multiplier.
- right_shift_i  in  SHIFT_WIDTH  shift amount, 0..31.
- add_i  in  WI  signed post-shift bias.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts.
- data_o  out  N×WI  signed saturated activations.

## Operation
- A beat is accepted when valid_i && ready_o. eps_mult_i, right_shift_i and add_i are captured with the beat and travel down the pipeline. A parameter change affects only beats accepted after the change.
- Stage S1 multiplies each lane: p = data × eps_mult. The multiplier is zero-extended and the product is PW = GELU_OUT_WIDTH+EPS_WIDTH+1 bits, signed.
- Stage S2 shifts each lane: s = (p + r) >>> right_shift.
  - The shift is arithmetic.
  - r is the rounding term described under Configuration.
  - The sum is computed at PW+1 bits, so the rounding add cannot overflow.
- Stage S3 adds and saturates each lane: t = s + sign-extended add_i, computed at PW+2 bits.
  - The result is clipped to [-2^(WI-1), 2^(WI-1)-1], i.e. [-128, 127] for WI=8.
- All lanes are independent and share the same parameters.

## Timing
- Latency is 3 cycles from acceptance to valid_o, with no backpressure.
- Throughput is 1 beat per cycle.
- Each stage k holds a valid bit v_k. Stage k loads when !v_k or stage k+1 loads. Stage 3 "loads" when !v_3 or ready_i.
- ready_o = !v_1 || S2 loads. The path from ready_i to ready_o is combinational.
- Bubbles collapse: an empty stage accepts even while downstream stalls.
- valid_o = v_3. data_o is held stable while valid_o && !ready_i.
- valid_o never drops until the beat is accepted.
- Simultaneous accept-in and drain-out in one cycle is legal and is the normal steady state.
- Reset:
  - All v_k = 0, valid_o = 0, data_o = 0. ready_o = 1 from the first cycle after reset release.
  - Data and parameter registers reset to 0.
  - Reset asserted mid-stream discards all in-flight beats; no partial output appears.
- No data register is enabled when its stage does not load, so stalled beats are never overwritten.

## Configuration
- ITA_REQUANT_ROUND_EN:
  - Defined: r = 1 << (right_shift-1) when right_shift > 0, else r = 0. This is round-half-up; for example, -37.5 becomes -37.
  - Undefined: r = 0, giving floor truncation. The rounding adder is removed from S2.
- Handshake and latency are identical in both builds.

## Structure
- These belong in ita_package:
  - GELU_OUT_WIDTH and WI, already present.
  - New constants REQ_EPS_WIDTH and REQ_SHIFT_WIDTH, used as parameter defaults.
  - A typedef requant_oup_t for one N×WI output beat.
- One sub-module, ita_requant_lane, is natural. It contains the combinational per-lane arithmetic (multiply, shift/round, add/clip), split by the pipeline registers owned by the parent. The parent instantiates it N times and owns the valid/ready control.

## Test plan
- Lane data 100, eps 3, shift 3, add -2 → data_o 36 with ITA_REQUANT_ROUND_EN, 35 without. valid_o rises 3 cycles after acceptance.
- Lane data -100, same parameters → -39 with rounding, -40 without.
- Saturation:
  - data 20000, eps 255, shift 0, add 0 → 127.
  - data -20000 → -128.
  - shift 0 with rounding on adds no rounding term.
- Continuous valid_i with ready_i toggling in the pattern 1,0,0,1 → no beat lost or duplicated, data_o stable during stalls, and ready_o low only when all 3 stages are full and ready_i is low.
- Parameters changed on every beat (eps 1,2,3, shift 0) on data 10 → outputs 10, 20, 30 in order, proving per-beat capture.
- Reset asserted with 3 beats in flight → valid_o 0 immediately. After release, the first new beat emerges at latency 3 with no stale data.
